// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared constants for the 1:32 pipelined demultiplexer tree.
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int N_LANES = 32;
  localparam int SEL_W   = 5;
  localparam int LEVELS  = 5;

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_LANES - 1);

  // Select bit steered on at tree level (1-based), MSB first.
  function automatic int level_bit(input int level);
    return SEL_W - level;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux1_2_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux1_2_reg
// Brief    : Registered 1:2 routing stage carrying valid, select, data, flag.
// Revision : 1.0 - initial release
// ============================================================================
module demux1_2_reg
  import demux_pkg::*;
#(
  parameter int DW  = 1,
  parameter int BIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [DW-1:0]    i_data,
  input  logic             i_flag,
  output logic             o_lo_valid,
  output logic [SEL_W-1:0] o_lo_sel,
  output logic [DW-1:0]    o_lo_data,
  output logic             o_lo_flag,
  output logic             o_hi_valid,
  output logic [SEL_W-1:0] o_hi_sel,
  output logic [DW-1:0]    o_hi_data,
  output logic             o_hi_flag
);

  logic             w_go_lo;
  logic             w_go_hi;

  logic             r_lo_valid;
  logic [SEL_W-1:0] r_lo_sel;
  logic [DW-1:0]    r_lo_data;
  logic             r_lo_flag;
  logic             r_hi_valid;
  logic [SEL_W-1:0] r_hi_sel;
  logic [DW-1:0]    r_hi_data;
  logic             r_hi_flag;

  assign w_go_hi = i_valid &  i_sel[BIT];
  assign w_go_lo = i_valid & ~i_sel[BIT];

  // The branch not taken loads zero so idle leaves never leak stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo_valid <= 1'b0;
      r_lo_sel   <= '0;
      r_lo_data  <= '0;
      r_lo_flag  <= 1'b0;
      r_hi_valid <= 1'b0;
      r_hi_sel   <= '0;
      r_hi_data  <= '0;
      r_hi_flag  <= 1'b0;
    end else if (i_flush) begin
      r_lo_valid <= 1'b0;
      r_lo_sel   <= '0;
      r_lo_data  <= '0;
      r_lo_flag  <= 1'b0;
      r_hi_valid <= 1'b0;
      r_hi_sel   <= '0;
      r_hi_data  <= '0;
      r_hi_flag  <= 1'b0;
    end else begin
      r_lo_valid <= w_go_lo;
      r_lo_sel   <= w_go_lo ? i_sel  : '0;
      r_lo_data  <= w_go_lo ? i_data : '0;
      r_lo_flag  <= w_go_lo & i_flag;
      r_hi_valid <= w_go_hi;
      r_hi_sel   <= w_go_hi ? i_sel  : '0;
      r_hi_data  <= w_go_hi ? i_data : '0;
      r_hi_flag  <= w_go_hi & i_flag;
    end
  end

  assign o_lo_valid = r_lo_valid;
  assign o_lo_sel   = r_lo_sel;
  assign o_lo_data  = r_lo_data;
  assign o_lo_flag  = r_lo_flag;
  assign o_hi_valid = r_hi_valid;
  assign o_hi_sel   = r_hi_sel;
  assign o_hi_data  = r_hi_data;
  assign o_hi_flag  = r_hi_flag;

endmodule
`default_nettype wire

// File: rtl/demux_1to32_pipe.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to32_pipe
// Brief    : 1:32 demultiplexer built as a 5-level registered binary tree,
//            with auto lane counter, per-lane capture word and word-done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to32_pipe
  import demux_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_valid,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  auto_mode,
  input  logic                  clear,
  output logic [N_LANES*DW-1:0] out_lane,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_sel,
  output logic [N_LANES*DW-1:0] cap_word,
  output logic                  word_done
);

  // Heap-numbered tree nodes: node 1 is the input, node n feeds 2n and 2n+1,
  // so leaf node N_LANES+l is lane l.
  localparam int N_NODES = 2 * N_LANES;

  logic                  w_node_valid [1:N_NODES-1];
  logic [SEL_W-1:0]      w_node_sel   [1:N_NODES-1];
  logic [DW-1:0]         w_node_data  [1:N_NODES-1];
  logic                  w_node_flag  [1:N_NODES-1];

  logic                  w_out_valid;
  logic [SEL_W-1:0]      w_out_sel;
  logic                  w_out_flag;

  logic [SEL_W-1:0]      r_cnt;
  logic [N_LANES*DW-1:0] r_cap;
  logic                  r_word_done;

  assign w_node_valid[1] = in_valid & ~clear;
  assign w_node_sel[1]   = auto_mode ? r_cnt : in_sel;
  assign w_node_data[1]  = in_data;
  assign w_node_flag[1]  = auto_mode;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    for (genvar i = 0; i < (1 << k); i++) begin : g_node
      localparam int NODE = (1 << k) + i;
      demux1_2_reg #(
        .DW  (DW),
        .BIT (level_bit(k + 1))
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (clear),
        .i_valid    (w_node_valid[NODE]),
        .i_sel      (w_node_sel[NODE]),
        .i_data     (w_node_data[NODE]),
        .i_flag     (w_node_flag[NODE]),
        .o_lo_valid (w_node_valid[2*NODE]),
        .o_lo_sel   (w_node_sel[2*NODE]),
        .o_lo_data  (w_node_data[2*NODE]),
        .o_lo_flag  (w_node_flag[2*NODE]),
        .o_hi_valid (w_node_valid[2*NODE+1]),
        .o_hi_sel   (w_node_sel[2*NODE+1]),
        .o_hi_data  (w_node_data[2*NODE+1]),
        .o_hi_flag  (w_node_flag[2*NODE+1])
      );
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    assign out_lane[l*DW +: DW] = w_node_data[N_LANES+l];
  end

  // At most one leaf is live and idle leaves are zero, so OR-reduction
  // recovers the valid, lane index and flag of the emerging item.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_sel   = '0;
    w_out_flag  = 1'b0;
    for (int l = 0; l < N_LANES; l++) begin
      w_out_valid = w_out_valid | w_node_valid[N_LANES+l];
      w_out_sel   = w_out_sel   | w_node_sel[N_LANES+l];
      w_out_flag  = w_out_flag  | w_node_flag[N_LANES+l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (in_valid && auto_mode) begin
      r_cnt <= r_cnt + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap       <= '0;
      r_word_done <= 1'b0;
    end else if (clear) begin
      r_cap       <= '0;
      r_word_done <= 1'b0;
    end else begin
      for (int l = 0; l < N_LANES; l++) begin
        if (w_node_valid[N_LANES+l]) begin
          r_cap[l*DW +: DW] <= w_node_data[N_LANES+l];
        end
      end
      r_word_done <= w_out_valid & w_out_flag & (w_out_sel == LAST_LANE);
    end
  end

  assign out_valid = w_out_valid;
  assign out_sel   = w_out_sel;
  assign cap_word  = r_cap;
  assign word_done = r_word_done;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to32_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to32_pipe
// Brief    : Randomized and directed bench against a queue-based lane model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to32_pipe;

  localparam int DW = 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_valid  = 1'b0;
  logic [4:0]    in_sel    = '0;
  logic          auto_mode = 1'b0;
  logic          clear     = 1'b0;
  logic [31:0]   out_lane;
  logic          out_valid;
  logic [4:0]    out_sel;
  logic [31:0]   cap_word;
  logic          word_done;

  int checks = 0;
  int errors = 0;
  int wd_cnt = 0;
  int ov_cnt = 0;

  demux_1to32_pipe #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .auto_mode (auto_mode),
    .clear     (clear),
    .out_lane  (out_lane),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .cap_word  (cap_word),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  // Model: each accepted item waits in a queue and emerges 5 edges later.
  typedef struct {
    int age;
    int lane;
    bit data;
    bit flag;
  } item_t;

  item_t       q[$];
  bit          m_valid = 1'b0;
  int          m_lane  = 0;
  bit          m_data  = 1'b0;
  bit          m_flag  = 1'b0;
  bit          m_wd    = 1'b0;
  logic [31:0] m_cap   = '0;
  int          m_cnt   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      item_t it;
      m_wd = !clear && m_valid && (m_lane == 31) && m_flag;
      if (clear) begin
        q.delete();
        m_valid = 1'b0;
        m_cap   = '0;
        m_cnt   = 0;
      end else begin
        if (m_valid) m_cap[m_lane] = m_data;
        m_valid = 1'b0;
        foreach (q[i]) q[i].age--;
        if (q.size() > 0 && q[0].age == 0) begin
          it      = q.pop_front();
          m_valid = 1'b1;
          m_lane  = it.lane;
          m_data  = it.data;
          m_flag  = it.flag;
        end
        if (in_valid) begin
          it.age  = 4;
          it.lane = auto_mode ? m_cnt : int'(in_sel);
          it.data = in_data[0];
          it.flag = auto_mode;
          q.push_back(it);
          if (auto_mode) m_cnt = (m_cnt + 1) % 32;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    m_valid = 1'b0;
    m_wd    = 1'b0;
    m_cap   = '0;
    m_cnt   = 0;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    e = m_valid ? (32'(m_data) << m_lane) : 32'd0;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) chk("out_sel", out_sel, m_lane);
    chk("out_lane", out_lane, e);
    chk("cap_word", cap_word, m_cap);
    chk("word_done", word_done, m_wd);
    if (word_done) wd_cnt++;
    if (out_valid) ov_cnt++;
  end

  task automatic drive(input logic v, input logic [4:0] s, input logic d,
                       input logic a, input logic c);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    auto_mode = a;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic mode;
    mode = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_lane", out_lane, 0);
    chk("reset_cap", cap_word, 0);
    rst_n = 1'b1;

    // Single manual item to lane 13
    drive(1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("manual_valid", out_valid, 1);
    chk("manual_sel", out_sel, 13);
    chk("manual_lane", out_lane, 32'h0000_2000);
    idle(1);
    chk("manual_cap", cap_word, 32'h0000_2000);

    // Back-to-back lanes 0, 31, 5
    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd31, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("b2b_0", {out_valid, out_sel}, {1'b1, 5'd0});
    idle(1);
    chk("b2b_1", {out_valid, out_sel}, {1'b1, 5'd31});
    idle(1);
    chk("b2b_2", {out_valid, out_sel}, {1'b1, 5'd5});
    idle(3);

    // Auto sweep of one full word, data 1,0,1,0...
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    wd_cnt = 0;
    for (int i = 0; i < 32; i++) drive(1'b1, 5'd0, (i % 2 == 0), 1'b1, 1'b0);
    idle(7);
    chk("auto_cap", cap_word, 32'h5555_5555);
    chk("auto_wd_count", wd_cnt, 1);
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("auto_wrap_sel", {out_valid, out_sel}, {1'b1, 5'd0});
    idle(3);

    // Mode switch: four auto items, one manual to lane 20, then auto resumes at 4
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    wd_cnt = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd20, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    idle(3);
    chk("switch_manual", {out_valid, out_sel}, {1'b1, 5'd20});
    idle(1);
    chk("switch_cnt_kept", {out_valid, out_sel}, {1'b1, 5'd4});
    idle(3);
    chk("switch_cap", cap_word, 32'h0010_001F);
    chk("switch_no_wd", wd_cnt, 0);

    // Clear with items in flight and one in the same cycle
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    ov_cnt = 0;
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
    idle(8);
    chk("clear_no_valid", ov_cnt, 0);
    chk("clear_cap", cap_word, 0);
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("clear_cnt_zero", {out_valid, out_sel}, {1'b1, 5'd0});
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), mode, 1'($urandom_range(0, 59) == 0));
    end
    idle(6);

    // Asynchronous reset in the middle of a stream
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd17, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_lane", out_lane, 0);
    chk("async_rst_cap", cap_word, 0);
    chk("async_rst_wd", word_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("post_rst_early", out_valid, 0);
    idle(1);
    chk("post_rst_item", {out_valid, out_sel}, {1'b1, 5'd7});
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_1to32_pipe.md
DEMUX_1TO32_PIPE -- requirements
Module: demux_1to32_pipe

Interface
REQ-001 Parameter: DW, 1, data width of each lane in bits.
REQ-002 Single clock; reset asynchronous, active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_data  input  DW  data to route.
REQ-006 in_valid  input  1  in_data/in_sel accepted this cycle; no backpressure.
REQ-007 in_sel  input  5  destination lane when auto_mode=0.
REQ-008 auto_mode  input  1  1 = destination from internal lane counter.
REQ-009 clear  input  1  synchronous flush of pipeline, counter and capture word.
REQ-010 out_lane  output  32*DW  per-lane routed data; lane i = bits [i*DW +: DW].
REQ-011 out_valid  output  1  out_lane carries one routed item.
REQ-012 out_sel  output  5  lane index of the item on out_lane.
REQ-013 cap_word  output  32*DW  per-lane capture register; holds the last value routed to each lane.
REQ-014 word_done  output  1  one-cycle pulse: auto-mode word completed.

Function
REQ-015 Effective select SHALL be cnt when auto_mode=1, else in_sel; sampled only when in_valid=1.
REQ-016 cnt (5 bit) SHALL increment on each accepted item while auto_mode=1, wrapping 31->0; it SHALL hold otherwise, including across mode switches.
REQ-017 Routing SHALL be a 5-level registered 1:2 tree, MSB first: level 1 on sel[4], level 5 on sel[0].
REQ-018 Each level SHALL register valid, remaining select bits, data and the auto flag of the item.
REQ-019 Latency SHALL be exactly 5 cycles from accepted in_valid to out_valid; throughput SHALL be one item per cycle, back-to-back.
REQ-020 Non-selected branches SHALL load zero every cycle; with out_valid=0, out_lane SHALL be all zero.
REQ-021 With out_valid=1, only lane out_sel of out_lane SHALL be non-zero-capable; all other lanes SHALL be zero.
REQ-022 Cycle after out_valid=1: cap_word lane out_sel <= routed data; other lanes hold.
REQ-023 word_done SHALL pulse for one cycle, aligned with the cap_word update, when the item's out_sel=31 and its carried auto flag=1.
REQ-024 Items already in flight SHALL keep their select when auto_mode or in_sel changes.
REQ-025 clear=1 SHALL zero cnt, cap_word and all pipeline valids at the next edge; an in_valid in the same cycle SHALL be dropped.
REQ-026 clear SHALL take priority over a same-cycle cap_word update and SHALL suppress word_done.

Reset
REQ-027 rst_n=0 SHALL asynchronously zero cnt, all pipeline registers, out_lane, out_valid, out_sel, cap_word and word_done.
REQ-028 Reset mid-stream SHALL discard all in-flight items; the first item after deassertion SHALL appear after the full 5-cycle latency.

Structure
REQ-029 Shared package demux_pkg SHALL hold N_LANES=32, SEL_W=5, LEVELS=5.
REQ-030 Sub-module demux1_2_reg (registered 1:2 stage carrying valid/sel/data/flag) SHALL be instantiated 31 times via generate, 2^(k-1) instances at level k.

Verification
REQ-031 Manual: in_sel=13, in_data=1, in_valid pulse at cycle 0 -> cycle 5: out_valid=1, out_sel=13, out_lane=32'h0000_2000; cycle 6: cap_word bit13=1.
REQ-032 Back-to-back: in_sel 0,31,5 on consecutive cycles -> out_valid high for 3 consecutive cycles, out_sel 0,31,5, no gaps.
REQ-033 Auto: 32 consecutive items, data alternating 1,0 -> cap_word=32'h5555_5555, single word_done pulse after lane 31, cnt wrapped to 0.
REQ-034 Mode switch: auto_mode=1 for items 0-3, then 0 with in_sel=20 -> lanes 0-3 then 20; cnt=4 kept; no word_done.
REQ-035 clear at cycle 2 after 3 items -> no out_valid ever, cap_word=0, cnt=0; same-cycle item dropped.
REQ-036 rst_n low mid-stream -> all outputs 0 immediately (asynchronously); post-release item emerges after 5 cycles.
